dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache that sits downstream of the pipeline's MEM stage, between the CPU data port and a 256-bit off-chip data memory. Hits complete combinationally. Misses raise `cpu_stall_o`, which freezes all pipeline registers and the PC, while an FSM writes back a dirty victim and refills the line.

---
 rtl/dcache_controller.sv | 163 ++++++++++++++++
 tb/tb_dcache_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache with miss FSM and 256-bit line memory port.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_controller #(
    parameter int SETS   = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 5;

    typedef enum logic [2:0] {S_IDLE, S_MISS, S_WB, S_REFILL, S_DONE} state_e;

    state_e             state_q;
    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [LINE_W-1:0]  line_q [SETS];
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [LINE_W-1:0]  mem_data_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         wsel;
    logic               hit;
    logic               serve;
    logic               wr_hit;
    logic               refill_ack;
    logic               unused_addr_lsb;

    assign idx             = cpu_addr_i[5 +: IDX_W];
    assign req_tag         = cpu_addr_i[31 -: TAG_W];
    assign wsel            = cpu_addr_i[4:2];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign hit        = cpu_req_i && valid_q[idx] && (tag_q[idx] == req_tag);
    // DONE re-presents the held request against the freshly filled line
    assign serve      = hit && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign wr_hit     = serve && cpu_we_i;
    assign refill_ack = (state_q == S_REFILL) && mem_ack_i;

    always_comb begin
        cpu_stall_o = 1'b0;
        case (state_q)
            S_IDLE:  cpu_stall_o = cpu_req_i && !hit;
            S_DONE:  cpu_stall_o = 1'b0;
            default: cpu_stall_o = 1'b1;
        endcase
    end

    assign cpu_data_o = serve ? line_q[idx][{wsel, 5'b00000} +: 32] : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_data_q <= '0;
        end else begin
            mem_req_q <= 1'b0;
            if (wr_hit) begin
                dirty_q[idx] <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_i && !hit) begin
                        state_q <= S_MISS;
                    end
                end
                S_MISS: begin
                    mem_req_q <= 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_q    <= S_WB;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= {tag_q[idx], idx, 5'b00000};
                        mem_data_q <= line_q[idx];
                    end else begin
                        state_q    <= S_REFILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {req_tag, idx, 5'b00000};
                    end
                end
                S_WB: begin
                    if (mem_ack_i) begin
                        state_q    <= S_REFILL;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {req_tag, idx, 5'b00000};
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        state_q      <= S_DONE;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and line arrays carry no reset; valid bits gate their use
    always_ff @(posedge clk_i) begin
        if (refill_ack) begin
            line_q[idx] <= mem_data_i;
            tag_q[idx]  <= req_tag;
        end else if (wr_hit) begin
            line_q[idx][{wsel, 5'b00000} +: 32] <= cpu_data_i;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (state_q == S_IDLE) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (cpu_req_i && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency (L = 10) line memory model.
module tb_dcache_controller;
    localparam int L = 10;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    logic auto_ack = 1'b0;
    logic man_ack  = 1'b0;
    logic auto_en  = 1'b1;
    assign mem_ack_i = auto_ack | man_ack;

    dcache_controller dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Backing store: pristine lines are generated, written-back lines are kept
    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 16'(i)};
        if (a == 32'h0000_0100) l[31:0] = 32'hDEAD_BEEF;
        return l;
    endfunction

    logic [255:0] wb_mem [logic [31:0]];
    int           req_cnt = 0;
    int           wb_cnt  = 0;
    int           rf_cnt  = 0;
    logic [31:0]  wb_addr = '0;
    logic [31:0]  rf_addr = '0;
    logic [255:0] wb_data = '0;
    logic [255:0] pend    = '0;
    logic         busy    = 1'b0;
    int           rem     = 0;

    always @(negedge clk) begin
        auto_ack = 1'b0;
        if (!rst_i) begin
            busy = 1'b0;
        end else if (busy) begin
            rem--;
            if (rem == 0) begin
                busy = 1'b0;
                if (auto_en) begin
                    auto_ack   = 1'b1;
                    mem_data_i = pend;
                end
            end
        end
        if (mem_req_o) begin
            req_cnt++;
            if (mem_we_o) begin
                wb_cnt++;
                wb_addr = mem_addr_o;
                wb_data = mem_data_o;
                wb_mem[mem_addr_o] = mem_data_o;
                pend = '0;
            end else begin
                rf_cnt++;
                rf_addr = mem_addr_o;
                pend = wb_mem.exists(mem_addr_o) ? wb_mem[mem_addr_o] : init_line(mem_addr_o);
            end
            busy = 1'b1;
            rem  = L;
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one access from just after a rising edge; returns stall length and serviced data
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rdata);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        stalls     = 0;
        @(negedge clk);
        while (cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        rdata = cpu_data_o;
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    int           st;
    int           r0;
    logic [31:0]  rd;
    logic [255:0] exp_wb;
    logic [31:0]  exp_hits;
    logic [31:0]  exp_misses;

    initial begin
`ifdef DCACHE_STATS_EN
        exp_hits   = 32'd3;
        exp_misses = 32'd2;
`else
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
`endif
        rst_i      = 1'b0;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'd0;
        cpu_data_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check32("rst_stall", 32'(cpu_stall_o), 32'd0);
        check32("rst_mem_req", 32'(mem_req_o), 32'd0);
        check32("rst_mem_we", 32'(mem_we_o), 32'd0);
        check32("rst_mem_addr", mem_addr_o, 32'd0);
        check256("rst_mem_data", mem_data_o, 256'd0);
        check32("rst_cpu_data", cpu_data_o, 32'd0);
        check32("rst_hit_cnt", hit_cnt_o, 32'd0);
        check32("rst_miss_cnt", miss_cnt_o, 32'd0);
        @(posedge clk);
        #1;

        r0 = req_cnt;
        access(1'b0, 32'h0000_0100, 32'd0, st, rd);
        check32("cold_stall", 32'(st), 32'd13);
        check32("cold_data", rd, 32'hDEAD_BEEF);
        check32("cold_reqs", 32'(req_cnt - r0), 32'd1);
        check32("cold_wb_cnt", 32'(wb_cnt), 32'd0);
        check32("cold_rf_addr", rf_addr, 32'h0000_0100);

        r0 = req_cnt;
        access(1'b0, 32'h0000_0104, 32'd0, st, rd);
        check32("hit104_stall", 32'(st), 32'd0);
        check32("hit104_data", rd, 32'h0100_0001);
        check32("hit104_reqs", 32'(req_cnt - r0), 32'd0);

        access(1'b1, 32'h0000_0108, 32'h1234_5678, st, rd);
        check32("store108_stall", 32'(st), 32'd0);
        access(1'b0, 32'h0000_0108, 32'd0, st, rd);
        check32("load108_stall", 32'(st), 32'd0);
        check32("load108_data", rd, 32'h1234_5678);

        r0 = req_cnt;
        exp_wb = init_line(32'h0000_0100);
        exp_wb[95:64] = 32'h1234_5678;
        access(1'b0, 32'h0000_0308, 32'd0, st, rd);
        check32("dirty_stall", 32'(st), 32'd24);
        check32("dirty_data", rd, 32'h0300_0002);
        check32("dirty_reqs", 32'(req_cnt - r0), 32'd2);
        check32("dirty_wb_cnt", 32'(wb_cnt), 32'd1);
        check32("dirty_wb_addr", wb_addr, 32'h0000_0100);
        check256("dirty_wb_line", wb_data, exp_wb);
        check32("dirty_rf_addr", rf_addr, 32'h0000_0300);

        check32("hit_cnt", hit_cnt_o, exp_hits);
        check32("miss_cnt", miss_cnt_o, exp_misses);

        auto_en    = 1'b0;
        r0         = req_cnt;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0100;
        repeat (4) @(posedge clk);
        #1;
        check32("midrf_stall", 32'(cpu_stall_o), 32'd1);
        check32("midrf_reqs", 32'(req_cnt - r0), 32'd1);
        check32("midrf_rf_addr", rf_addr, 32'h0000_0100);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        check32("postrst_mem_req", 32'(mem_req_o), 32'd0);
        check32("postrst_stall", 32'(cpu_stall_o), 32'd0);
        check32("postrst_mem_addr", mem_addr_o, 32'd0);
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        check32("lateack_stall", 32'(cpu_stall_o), 32'd0);
        check32("lateack_mem_req", 32'(mem_req_o), 32'd0);

        auto_en = 1'b1;
        r0 = req_cnt;
        access(1'b0, 32'h0000_0300, 32'd0, st, rd);
        check32("remiss_stall", 32'(st), 32'd13);
        check32("remiss_data", rd, 32'h0300_0000);
        check32("remiss_reqs", 32'(req_cnt - r0), 32'd1);
        check32("remiss_rf_addr", rf_addr, 32'h0000_0300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
